julia_pixel_sequencer: RTL and testbench

Frame-level scheduler between the HPS parameter PIOs (`init_x`, `init_y`, `step`, `num_iter`) and the on-chip VGA pixel buffer (s1 port, 19-bit address, 8-bit data). On `start` it walks every pixel in raster order and issues one fixed-point complex coordinate per pixel to the Julia solver over a valid/ready handshake. It takes in-order iteration counts back, maps each count to an RGB332 colour and writes it to the buffer. It also measures the frame time in milliseconds for the `frame_ms` PIO.

---
 rtl/julia_pkg.sv | 25 ++
 rtl/ms_timer.sv | 56 +++++
 rtl/julia_pixel_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_julia_pixel_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and helpers for the Julia frame pipeline: coordinate/iteration
// types, buffer address type and the iteration-count to RGB332 colour map.
package julia_pkg;

    typedef logic signed [26:0] coord_t;
    typedef logic [9:0]         iter_t;
    typedef logic [18:0]        buf_addr_t;

    localparam int unsigned COORD_FRAC = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Points that reached the iteration limit are painted black.
    function automatic logic [7:0] iter_to_rgb332(input iter_t iter, input iter_t max_iter);
        if (iter >= max_iter) begin
            return 8'h00;
        end
        return {iter[2:0], iter[5:3], iter[7:6]};
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond frame timer: cycle prescaler feeding a saturating ms counter,
// with a clear for frame start and a capture register for the frame length.
module ms_timer #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        capture_i,
    output logic [31:0] frame_ms_o
);

    localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
    localparam int unsigned CYC_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [31:0]      ms_q, ms_d;
    logic [31:0]      frame_ms_q, frame_ms_d;

    // Capture takes the count including this cycle's tick, so the result is floor(cycles/ms).
    always_comb begin
        cyc_d      = cyc_q;
        ms_d       = ms_q;
        frame_ms_d = frame_ms_q;
        if (cyc_q == CYC_W'(CYC_PER_MS - 1)) begin
            cyc_d = '0;
            if (ms_q != '1) begin
                ms_d = ms_q + 32'd1;
            end
        end else begin
            cyc_d = cyc_q + 1'b1;
        end
        if (capture_i) begin
            frame_ms_d = ms_d;
        end
        if (clear_i) begin
            cyc_d = '0;
            ms_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q      <= '0;
            ms_q       <= '0;
            frame_ms_q <= '0;
        end else begin
            cyc_q      <= cyc_d;
            ms_q       <= ms_d;
            frame_ms_q <= frame_ms_d;
        end
    end

    assign frame_ms_o = frame_ms_q;

endmodule

// File: rtl/julia_pixel_sequencer.sv
// Frame scheduler: issues per-pixel coordinates to the Julia solver in raster
// order, writes returned iteration counts as RGB332 into the VGA pixel buffer.
module julia_pixel_sequencer
    import julia_pkg::*;
#(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [26:0] init_x,
    input  logic [26:0] init_y,
    input  logic [26:0] step,
    input  logic [9:0]  num_iter,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] frame_ms,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [26:0] pix_cr,
    output logic [26:0] pix_ci,
    output logic [9:0]  pix_max_iter,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [9:0]  res_iter,
    output logic [18:0] buf_address,
    output logic        buf_write,
    output logic [7:0]  buf_writedata,
    output logic        buf_chipselect,
    output logic        buf_clken
);

    localparam int unsigned N_PIX = H_RES * V_RES;
    localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    seq_state_t       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    coord_t           init_x_q, init_x_d;
    coord_t           step_q, step_d;
    logic             pix_valid_q, pix_valid_d;
    coord_t           pix_cr_q, pix_cr_d;
    coord_t           pix_ci_q, pix_ci_d;
    iter_t            pix_max_iter_q, pix_max_iter_d;
    buf_addr_t        wb_addr_q, wb_addr_d;
    buf_addr_t        buf_address_q, buf_address_d;
    logic [7:0]       buf_writedata_q, buf_writedata_d;
    logic             buf_write_q, buf_write_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             timer_clear_c;
    logic             timer_capture_c;
    logic             res_fire_c;

    assign res_fire_c = res_valid && (state_q == ST_RUN);

    // Next-state logic: issue counters and writeback advance independently in RUN.
    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        init_x_d        = init_x_q;
        step_d          = step_q;
        pix_valid_d     = pix_valid_q;
        pix_cr_d        = pix_cr_q;
        pix_ci_d        = pix_ci_q;
        pix_max_iter_d  = pix_max_iter_q;
        wb_addr_d       = wb_addr_q;
        buf_address_d   = buf_address_q;
        buf_writedata_d = buf_writedata_q;
        buf_write_d     = 1'b0;
        busy_d          = busy_q;
        frame_done_d    = 1'b0;
        timer_clear_c   = 1'b0;
        timer_capture_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_RUN;
                    busy_d         = 1'b1;
                    init_x_d       = coord_t'(init_x);
                    step_d         = coord_t'(step);
                    pix_valid_d    = 1'b1;
                    pix_cr_d       = coord_t'(init_x);
                    pix_ci_d       = coord_t'(init_y);
                    pix_max_iter_d = iter_t'(num_iter);
                    col_d          = '0;
                    row_d          = '0;
                    wb_addr_d      = '0;
                    timer_clear_c  = 1'b1;
                end
            end
            ST_RUN: begin
                if (pix_valid_q && pix_ready) begin
                    if (col_q == COL_W'(H_RES - 1)) begin
                        col_d    = '0;
                        pix_cr_d = init_x_q;
                        pix_ci_d = pix_ci_q - step_q;
                        if (row_q == ROW_W'(V_RES - 1)) begin
                            pix_valid_d = 1'b0;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d    = col_q + 1'b1;
                        pix_cr_d = pix_cr_q + step_q;
                    end
                end
                if (res_fire_c) begin
                    buf_write_d     = 1'b1;
                    buf_address_d   = wb_addr_q;
                    buf_writedata_d = iter_to_rgb332(iter_t'(res_iter), pix_max_iter_q);
                    wb_addr_d       = wb_addr_q + 1'b1;
                    if (wb_addr_q == buf_addr_t'(N_PIX - 1)) begin
                        state_d         = ST_DONE;
                        busy_d          = 1'b0;
                        frame_done_d    = 1'b1;
                        timer_capture_c = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            col_q           <= '0;
            row_q           <= '0;
            init_x_q        <= '0;
            step_q          <= '0;
            pix_valid_q     <= 1'b0;
            pix_cr_q        <= '0;
            pix_ci_q        <= '0;
            pix_max_iter_q  <= '0;
            wb_addr_q       <= '0;
            buf_address_q   <= '0;
            buf_writedata_q <= '0;
            buf_write_q     <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            init_x_q        <= init_x_d;
            step_q          <= step_d;
            pix_valid_q     <= pix_valid_d;
            pix_cr_q        <= pix_cr_d;
            pix_ci_q        <= pix_ci_d;
            pix_max_iter_q  <= pix_max_iter_d;
            wb_addr_q       <= wb_addr_d;
            buf_address_q   <= buf_address_d;
            buf_writedata_q <= buf_writedata_d;
            buf_write_q     <= buf_write_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    ms_timer #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (timer_clear_c),
        .capture_i  (timer_capture_c),
        .frame_ms_o (frame_ms)
    );

    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign pix_valid      = pix_valid_q;
    assign pix_cr         = pix_cr_q;
    assign pix_ci         = pix_ci_q;
    assign pix_max_iter   = pix_max_iter_q;
    assign res_ready      = (state_q == ST_RUN);
    assign buf_address    = buf_address_q;
    assign buf_write      = buf_write_q;
    assign buf_writedata  = buf_writedata_q;
    assign buf_chipselect = buf_write_q;
    assign buf_clken      = buf_write_q;

endmodule

// File: tb/tb_julia_pixel_sequencer.sv
// Scoreboard bench: a solver model answers coordinates, expected coordinates,
// buffer writes and frame times are queued and checked by separate monitors.
module tb_julia_pixel_sequencer;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;
    localparam int CPM  = 4;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [26:0] init_x, init_y, step;
    logic [9:0]  num_iter;
    logic        busy, frame_done;
    logic [31:0] frame_ms;
    logic        pix_valid, pix_ready;
    logic [26:0] pix_cr, pix_ci;
    logic [9:0]  pix_max_iter;
    logic        res_valid, res_ready;
    logic [9:0]  res_iter;
    logic [18:0] buf_address;
    logic        buf_write, buf_chipselect, buf_clken;
    logic [7:0]  buf_writedata;

    always #5 clk = ~clk;

    julia_pixel_sequencer #(.H_RES(H), .V_RES(V), .CLK_HZ(4000)) dut (
        .clk(clk), .reset(reset), .start(start),
        .init_x(init_x), .init_y(init_y), .step(step), .num_iter(num_iter),
        .busy(busy), .frame_done(frame_done), .frame_ms(frame_ms),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_cr(pix_cr), .pix_ci(pix_ci), .pix_max_iter(pix_max_iter),
        .res_valid(res_valid), .res_ready(res_ready), .res_iter(res_iter),
        .buf_address(buf_address), .buf_write(buf_write), .buf_writedata(buf_writedata),
        .buf_chipselect(buf_chipselect), .buf_clken(buf_clken)
    );

    typedef struct { logic [26:0] cr; logic [26:0] ci; logic [9:0] mi; } coord_exp_t;
    typedef struct { int it; int t; } res_t;
    typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;

    coord_exp_t exp_coord[$];
    res_t       pend[$];
    wr_t        exp_wr[$];
    int         exp_ms[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int done_cnt = 0, frames = 0;
    bit ready_rand = 0, echo = 0, junk = 0, mon_en = 0;
    int lat = 1, hold_until = 0, st_cyc = 0, issued = 0, accepted = 0;
    logic [9:0] frame_max = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [7:0] ref_colour(input int it, input int mx);
        if (it >= mx) return 8'h00;
        return 8'(((it % 8) * 32) + (((it / 8) % 8) * 4) + ((it / 64) % 4));
    endfunction

    // Solver model: takes coordinates, returns iteration counts in order after a latency.
    coord_exp_t ce;
    res_t       rr;
    wr_t        ww;
    bit         stall_prev = 0;
    logic [26:0] sv_cr, sv_ci;
    logic [9:0]  sv_mi;
    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
            stall_prev = 0;
            pix_ready  = 1'b0;
            res_valid  = 1'b0;
            res_iter   = '0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", pix_valid, 1'b1);
                chk("stall_cr", pix_cr, sv_cr);
                chk("stall_ci", pix_ci, sv_ci);
                chk("stall_max_iter", pix_max_iter, sv_mi);
            end
            pix_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                res_valid = 1'b1;
                res_iter  = 10'($urandom);
                chk("res_ready_idle", res_ready, 1'b0);
            end else if (pend.size() > 0 && pend[0].t <= cyc && cyc >= hold_until) begin
                res_valid = 1'b1;
                res_iter  = 10'(pend[0].it);
            end else begin
                res_valid = 1'b0;
                res_iter  = 10'($urandom);
            end
            if (pix_valid && pix_ready) begin
                if (exp_coord.size() == 0) begin
                    flag("pix_extra_transfer");
                end else begin
                    ce = exp_coord.pop_front();
                    chk("pix_cr", pix_cr, ce.cr);
                    chk("pix_ci", pix_ci, ce.ci);
                    chk("pix_max_iter", pix_max_iter, ce.mi);
                end
                if (echo) rr.it = issued;
                else if ($urandom_range(0, 3) == 0) rr.it = int'(frame_max);
                else rr.it = int'($urandom_range(0, 1023));
                rr.t = cyc + lat;
                pend.push_back(rr);
                issued++;
            end
            stall_prev = pix_valid && !pix_ready;
            sv_cr = pix_cr;
            sv_ci = pix_ci;
            sv_mi = pix_max_iter;
            if (res_valid && res_ready && !junk) begin
                ww.addr = 19'(accepted);
                ww.data = ref_colour(pend[0].it, int'(frame_max));
                exp_wr.push_back(ww);
                void'(pend.pop_front());
                accepted++;
                if (accepted == NPIX) exp_ms.push_back((cyc - st_cyc) / CPM);
            end
        end
    end

    // Buffer/frame monitor: pops expected writes and frame times as the DUT presents them.
    wr_t mw;
    bit  prev_busy = 0, prev_done = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (buf_write) begin
                chk("buf_chipselect", buf_chipselect, 1'b1);
                chk("buf_clken", buf_clken, 1'b1);
                if (exp_wr.size() == 0) begin
                    flag("unexpected_buf_write");
                end else begin
                    mw = exp_wr.pop_front();
                    chk("buf_address", buf_address, mw.addr);
                    chk("buf_writedata", buf_writedata, mw.data);
                end
            end else begin
                chk("buf_strobes_idle", {buf_chipselect, buf_clken}, 2'b00);
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_busy_low", busy, 1'b0);
                chk("done_with_last_write", buf_write, 1'b1);
                chk("busy_before_done", prev_busy, 1'b1);
                chk("done_single_pulse", prev_done, 1'b0);
                if (exp_ms.size() == 0) flag("unexpected_frame_done");
                else chk("frame_ms", frame_ms, 64'(exp_ms.pop_front()));
            end
            prev_busy = busy;
            prev_done = frame_done;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_ms"}, frame_ms, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_cr"}, pix_cr, 0);
        chk({tag, "_pix_ci"}, pix_ci, 0);
        chk({tag, "_pix_max_iter"}, pix_max_iter, 0);
        chk({tag, "_res_ready"}, res_ready, 0);
        chk({tag, "_buf"}, {buf_address, buf_write, buf_writedata, buf_chipselect, buf_clken}, 0);
    endtask

    // Called at posedge+2; start is presented in the current cycle.
    task automatic start_frame(input logic [26:0] x, input logic [26:0] y, input logic [26:0] s,
                               input logic [9:0] n, input bit rnd, input int l, input bit ec,
                               input bit hold);
        coord_exp_t e;
        logic [26:0] c, r;
        ready_rand = rnd; lat = l; echo = ec; frame_max = n;
        issued = 0; accepted = 0;
        for (int i = 0; i < NPIX; i++) begin
            c = 27'(i % H);
            r = 27'(i / H);
            e.cr = x + c * s;
            e.ci = y - r * s;
            e.mi = n;
            exp_coord.push_back(e);
        end
        init_x = x; init_y = y; step = s; num_iter = n;
        start = 1'b1;
        st_cyc = cyc;
        hold_until = hold ? cyc + 33 : 0;
        frames++;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("pix_valid_after_start", pix_valid, 1'b1);
        init_x = 27'($urandom); init_y = 27'($urandom); step = 27'($urandom);
        num_iter = 10'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt >= frames) break;
            @(posedge clk); #2;
        end
        if (done_cnt < frames) flag("frame_done_timeout");
        chk("coords_left", exp_coord.size(), 0);
        chk("writes_left", exp_wr.size(), 0);
        chk("ms_left", exp_ms.size(), 0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        init_x = '0; init_y = '0; step = '0; num_iter = '0;
        pix_ready = 1'b0; res_valid = 1'b0; res_iter = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        reset = 1'b0;
        mon_en = 1;
        @(posedge clk); #2;

        start_frame(27'h0000000, 27'h0800000, 27'h0200000, 10'd5, 0, 1, 1, 0);
        wait_done();

        start_frame(27'($urandom), 27'($urandom), 27'($urandom), 10'd300, 0, 1, 0, 1);
        wait_done();
        chk("frame_ms_40_cycles", frame_ms, 10);

        for (int k = 0; k < 6; k++) begin
            start_frame(27'($urandom), 27'($urandom), 27'($urandom),
                        10'($urandom_range(1, 1023)), 1, $urandom_range(1, 4), k[0], 0);
            if (k == 2) begin
                repeat (2) @(posedge clk);
                #2;
                start = 1'b1;
                init_x = 27'($urandom);
                @(posedge clk); #2;
                start = 1'b0;
            end
            wait_done();
        end

        start_frame(27'h0100000, 27'h7F00000, 27'h0040000, 10'd64, 0, 3, 0, 0);
        for (int i = 0; i < 100 && issued < 3; i++) begin
            @(posedge clk); #2;
        end
        chk("reached_pixel_3", issued >= 3, 1'b1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        exp_coord.delete(); exp_wr.delete(); exp_ms.delete();
        issued = 0; accepted = 0;
        frames = done_cnt;
        check_zero("mid_reset");
        junk = 1;
        repeat (4) @(posedge clk);
        #2;
        junk = 0;
        @(posedge clk); #2;

        start_frame(27'h0100000, 27'h7F00000, 27'h0040000, 10'd64, 0, 3, 0, 0);
        wait_done();

        start = 1'b1; reset = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_with_reset_busy", busy, 1'b0);
            chk("start_with_reset_pix_valid", pix_valid, 1'b0);
            @(posedge clk); #2;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
